// File: rtl/sonic_constants.sv
// Shared constants for the DMA programming sequencer.
//   seq_state_t   : sequencer FSM states
//   DW*_IDX       : register word index within a channel's descriptor header
//   SRST_PATTERN  : DW0 low half that the register block treats as a soft reset
//   SIZE_CLAMP    : replacement size so a real descriptor count never aliases it
//   prg_addr()    : register byte address for (channel, dword)
package sonic_constants;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRST,
    ST_DW1,
    ST_DW2,
    ST_DW0,
    ST_DW3,
    ST_GAP,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0]  DW0_IDX      = 2'b00;
  localparam logic [1:0]  DW1_IDX      = 2'b01;
  localparam logic [1:0]  DW2_IDX      = 2'b10;
  localparam logic [1:0]  DW3_IDX      = 2'b11;

  localparam logic [15:0] SRST_PATTERN = 16'hFFFF;
  localparam logic [15:0] SIZE_CLAMP   = 16'hFFFE;

  function automatic logic [7:0] prg_addr(input logic ch, input logic [1:0] dw);
    return {3'b000, ch, dw, 2'b00};
  endfunction

endpackage

// File: rtl/sonic_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk_in, rstn : clock, asynchronous active-low reset
//   req          : request per requester
//   accept       : the current grant was taken this cycle
//   grant        : one-hot grant (zero when no request)
//   grant_idx    : index of the granted requester (only meaningful when grant != 0)
// The priority pointer starts at requester 0 and moves past the winner on accept.
module sonic_rr_arb2 (
  input  logic       clk_in,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic ptr;

  always_comb begin
    grant     = 2'b00;
    grant_idx = ptr;
    if (!req[ptr] && req[~ptr]) begin
      grant_idx = ~ptr;
    end
    if (req[grant_idx]) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant_idx;
    end
  end

endmodule

// File: rtl/sonic_dma_prg_seq.sv
// DMA descriptor-header programming sequencer.
// Accepts a request from one of two DMA channels (round-robin) and replays the
// channel's descriptor header into the DMA programming register block as a
// series of single-cycle register writes separated by idle gaps.
//   clk_in, rstn          : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-channel handshake (bit0 write-DMA, bit1 read-DMA)
//   req_last_only         : 1 = only update DW3 (rc_last)
//   req_size, req_rc_last : 2x16 packed, channel i at [16*i +: 16]
//   req_base              : 2x64 packed, channel i at [64*i +: 64]
//   req_ctrl              : 2x12 packed {rundma, msi_tc[2:0], msi_num[4:0], eplast_ena, msi, 0}
//   dma_prg_wrena/wrdata/addr : register write port (data/addr are 0 when idle)
//   busy                  : sequencer not idle
//   done                  : one-cycle completion pulse per channel
//   cfg_err               : one-cycle pulse when an accepted size was 16'hFFFF
module sonic_dma_prg_seq
  import sonic_constants::*;
#(
  parameter int GAP_CYCLES  = 2,
  parameter int RESET_FIRST = 1
) (
  input  logic         clk_in,
  input  logic         rstn,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_last_only,
  input  logic [31:0]  req_size,
  input  logic [31:0]  req_rc_last,
  input  logic [127:0] req_base,
  input  logic [23:0]  req_ctrl,
  output logic         dma_prg_wrena,
  output logic [31:0]  dma_prg_wrdata,
  output logic [7:0]   dma_prg_addr,
  output logic         busy,
  output logic [1:0]   done,
  output logic         cfg_err
);

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  seq_state_t  state, nxt_state;
  seq_state_t  ret_state, nxt_ret;
  logic [3:0]  gap_cnt, nxt_gap;

  logic        cap_ch, n_ch;
  logic        cap_last_only, n_last_only;
  logic [15:0] cap_size, n_size;
  logic [15:0] cap_rc_last, n_rc_last;
  logic [63:0] cap_base, n_base;
  logic [11:0] cap_ctrl, n_ctrl;

  logic        rdy_en;
  logic [1:0]  grant;
  logic        grant_idx;
  logic        accept;
  logic [39:0] nxt_word;

  // ctrl bit 0 is a reserved zero and is never forwarded
  logic        unused_ctrl_bits;
  assign unused_ctrl_bits = req_ctrl[0] ^ req_ctrl[12];

  sonic_rr_arb2 u_arb (
    .clk_in    (clk_in),
    .rstn      (rstn),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // rdy_en mirrors "state is IDLE" but stays low while in reset
  assign req_ready = grant & {2{rdy_en}};
  assign accept    = |(req_valid & req_ready);

  function automatic logic is_write(input seq_state_t st);
    return (st == ST_SRST) || (st == ST_DW1) || (st == ST_DW2) ||
           (st == ST_DW0)  || (st == ST_DW3);
  endfunction

  function automatic seq_state_t follow(input seq_state_t st);
    case (st)
      ST_SRST: return ST_DW1;
      ST_DW1:  return ST_DW2;
      ST_DW2:  return ST_DW0;
      ST_DW0:  return ST_DW3;
      default: return ST_DONE;
    endcase
  endfunction

  // {addr, data} for the write issued in state st; zero for non-write states
  function automatic logic [39:0] wr_word(
    input seq_state_t  st,
    input logic        ch,
    input logic [15:0] size,
    input logic [63:0] base,
    input logic [15:0] rc_last,
    input logic [11:0] ctrl
  );
    logic [15:0] sz;
    sz = (size == SRST_PATTERN) ? SIZE_CLAMP : size;
    case (st)
      ST_SRST: return {prg_addr(ch, DW0_IDX), 16'h0000, SRST_PATTERN};
      ST_DW1:  return {prg_addr(ch, DW1_IDX), base[63:32]};
      ST_DW2:  return {prg_addr(ch, DW2_IDX), base[31:0]};
      ST_DW0:  return {prg_addr(ch, DW0_IDX), ctrl[11], ctrl[10:8], 3'b000,
                       ctrl[7:3], 1'b0, ctrl[2:1], ch, sz};
      ST_DW3:  return {prg_addr(ch, DW3_IDX), 16'h0000, rc_last};
      default: return 40'h0;
    endcase
  endfunction

  always_comb begin
    nxt_state   = state;
    nxt_ret     = ret_state;
    nxt_gap     = gap_cnt;
    n_ch        = cap_ch;
    n_last_only = cap_last_only;
    n_size      = cap_size;
    n_rc_last   = cap_rc_last;
    n_base      = cap_base;
    n_ctrl      = cap_ctrl;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          n_ch        = grant_idx;
          n_last_only = grant_idx ? req_last_only[1] : req_last_only[0];
          n_size      = grant_idx ? req_size[31:16]    : req_size[15:0];
          n_rc_last   = grant_idx ? req_rc_last[31:16] : req_rc_last[15:0];
          n_base      = grant_idx ? req_base[127:64]   : req_base[63:0];
          n_ctrl      = grant_idx ? {req_ctrl[23:13], 1'b0} : {req_ctrl[11:1], 1'b0};
          if (n_last_only) begin
            nxt_state = ST_DW3;
          end else if (RESET_FIRST != 0) begin
            nxt_state = ST_SRST;
          end else begin
            nxt_state = ST_DW1;
          end
        end
      end
      ST_SRST, ST_DW1, ST_DW2, ST_DW0, ST_DW3: begin
        if (GAP_CYCLES == 0) begin
          nxt_state = follow(state);
        end else begin
          nxt_state = ST_GAP;
          nxt_ret   = follow(state);
          nxt_gap   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          nxt_state = ret_state;
        end else begin
          nxt_gap = gap_cnt - 4'd1;
        end
      end
      ST_DONE: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
    nxt_word = wr_word(nxt_state, n_ch, n_size, n_base, n_rc_last, n_ctrl);
  end

  // State and all outputs are registered from the next-state decode, so the
  // write for a state appears on the port in the cycle the FSM occupies it.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      ret_state      <= ST_IDLE;
      gap_cnt        <= 4'd0;
      cap_ch         <= 1'b0;
      cap_last_only  <= 1'b0;
      cap_size       <= 16'h0;
      cap_rc_last    <= 16'h0;
      cap_base       <= 64'h0;
      cap_ctrl       <= 12'h0;
      rdy_en         <= 1'b0;
      busy           <= 1'b0;
      dma_prg_wrena  <= 1'b0;
      dma_prg_wrdata <= 32'h0;
      dma_prg_addr   <= 8'h0;
      done           <= 2'b00;
      cfg_err        <= 1'b0;
    end else begin
      state          <= nxt_state;
      ret_state      <= nxt_ret;
      gap_cnt        <= nxt_gap;
      cap_ch         <= n_ch;
      cap_last_only  <= n_last_only;
      cap_size       <= n_size;
      cap_rc_last    <= n_rc_last;
      cap_base       <= n_base;
      cap_ctrl       <= n_ctrl;
      rdy_en         <= (nxt_state == ST_IDLE);
      busy           <= (nxt_state != ST_IDLE);
      dma_prg_wrena  <= is_write(nxt_state);
      dma_prg_addr   <= nxt_word[39:32];
      dma_prg_wrdata <= nxt_word[31:0];
      done           <= (nxt_state == ST_DONE) ? (n_ch ? 2'b10 : 2'b01) : 2'b00;
      cfg_err        <= accept && (n_size == SRST_PATTERN);
    end
  end

endmodule

// File: tb/tb_sonic_dma_prg_seq.sv
module tb_sonic_dma_prg_seq;

  logic         clk_in = 1'b0;
  logic         rstn;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_last_only;
  logic [31:0]  req_size;
  logic [31:0]  req_rc_last;
  logic [127:0] req_base;
  logic [23:0]  req_ctrl;
  logic         dma_prg_wrena;
  logic [31:0]  dma_prg_wrdata;
  logic [7:0]   dma_prg_addr;
  logic         busy;
  logic [1:0]   done;
  logic         cfg_err;

  sonic_dma_prg_seq #(.GAP_CYCLES(2), .RESET_FIRST(1)) dut (
    .clk_in         (clk_in),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_last_only  (req_last_only),
    .req_size       (req_size),
    .req_rc_last    (req_rc_last),
    .req_base       (req_base),
    .req_ctrl       (req_ctrl),
    .dma_prg_wrena  (dma_prg_wrena),
    .dma_prg_wrdata (dma_prg_wrdata),
    .dma_prg_addr   (dma_prg_addr),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc = cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Activity logs, sampled on the falling edge
  int          w_cyc[$];
  logic [7:0]  w_addr[$];
  logic [31:0] w_data[$];
  int          d_cyc[$];
  logic [1:0]  d_val[$];
  int          e_cyc[$];
  int          a_cyc[$];
  int          a_ch[$];
  int          both_bad = 0;
  int          idle_bad = 0;

  always @(negedge clk_in) begin
    if (dma_prg_wrena) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(dma_prg_addr);
      w_data.push_back(dma_prg_wrdata);
    end else if (dma_prg_addr != 8'h0 || dma_prg_wrdata != 32'h0) begin
      idle_bad++;
    end
    if (done != 2'b00) begin
      d_cyc.push_back(cyc);
      d_val.push_back(done);
    end
    if (cfg_err) e_cyc.push_back(cyc);
    if ((req_valid & req_ready) != 2'b00) begin
      a_cyc.push_back(cyc);
      a_ch.push_back(req_ready[1] ? 1 : 0);
    end
    if (req_ready == 2'b11) both_bad++;
  end

  task automatic clr();
    w_cyc.delete(); w_addr.delete(); w_data.delete();
    d_cyc.delete(); d_val.delete(); e_cyc.delete();
    a_cyc.delete(); a_ch.delete();
  endtask

  task automatic set_req(input int ch, input logic lo, input logic [15:0] size,
                         input logic [63:0] base, input logic [15:0] rcl,
                         input logic [11:0] ctrl);
    if (ch == 0) begin
      req_last_only[0] = lo; req_size[15:0] = size; req_base[63:0] = base;
      req_rc_last[15:0] = rcl; req_ctrl[11:0] = ctrl;
    end else begin
      req_last_only[1] = lo; req_size[31:16] = size; req_base[127:64] = base;
      req_rc_last[31:16] = rcl; req_ctrl[23:12] = ctrl;
    end
  endtask

  task automatic do_req(input int ch, input logic lo, input logic [15:0] size,
                        input logic [63:0] base, input logic [15:0] rcl,
                        input logic [11:0] ctrl, output int t0);
    bit got;
    got = 1'b0;
    t0  = 0;
    set_req(ch, lo, size, base, rcl, ctrl);
    req_valid[ch] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk_in);
      if (req_valid[ch] && req_ready[ch]) begin
        got = 1'b1;
        t0  = cyc;
      end
    end
    chk("accept", 64'(got), 64'd1);
    @(posedge clk_in); #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 100 && d_cyc.size() < n; k++) @(posedge clk_in);
    chk("done_seen", 64'(d_cyc.size()), 64'(n));
  endtask

  task automatic check_wr(input string tag, input int i, input int t0, input int rel,
                          input logic [7:0] addr, input logic [31:0] data);
    if (i >= w_cyc.size()) begin
      chk({tag, "_missing"}, 64'(w_cyc.size()), 64'(i + 1));
    end else begin
      chk({tag, "_cyc"},  64'(w_cyc[i] - t0), 64'(rel));
      chk({tag, "_addr"}, 64'(w_addr[i]), 64'(addr));
      chk({tag, "_data"}, 64'(w_data[i]), 64'(data));
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); #1;
    rstn = 1'b1;
    @(posedge clk_in); #1;
  endtask

  int t0, cnt;
  logic [1:0] acc;

  initial begin
    rstn = 1'b0;
    req_valid = 2'b11;
    req_last_only = 2'b00;
    req_size = '0; req_rc_last = '0; req_base = '0; req_ctrl = '0;

    // Reset state, with requests pending
    #12;
    chk("rst_ready",  64'(req_ready), 64'd0);
    chk("rst_wrena",  64'(dma_prg_wrena), 64'd0);
    chk("rst_addr",   64'(dma_prg_addr), 64'd0);
    chk("rst_data",   64'(dma_prg_wrdata), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_cfgerr", 64'(cfg_err), 64'd0);
    req_valid = 2'b00;
    do_reset();

    // Full sequence on ch0
    clr();
    do_req(0, 1'b0, 16'd8, 64'h1_2345_6780, 16'd3, 12'b1_011_10101_1_1_0, t0);
    wait_done(1);
    chk("t1_nwr", 64'(w_cyc.size()), 64'd5);
    check_wr("t1_srst", 0, t0, 1,  8'h00, 32'h0000FFFF);
    check_wr("t1_dw1",  1, t0, 4,  8'h04, 32'h00000001);
    check_wr("t1_dw2",  2, t0, 7,  8'h08, 32'h23456780);
    check_wr("t1_dw0",  3, t0, 10, 8'h00, 32'hB1560008);
    check_wr("t1_dw3",  4, t0, 13, 8'h0C, 32'h00000003);
    if (d_cyc.size() > 0) begin
      chk("t1_done_cyc", 64'(d_cyc[0] - t0), 64'd16);
      chk("t1_done_val", 64'(d_val[0]), 64'd1);
    end
    chk("t1_cfgerr", 64'(e_cyc.size()), 64'd0);

    // Both channels at once after reset: ch0 (last_only) first, then ch1 full
    do_reset();
    clr();
    set_req(0, 1'b1, 16'd0, 64'h0, 16'h0009, 12'h0);
    set_req(1, 1'b0, 16'd2, 64'hAABBCCDD_11223344, 16'h0007, 12'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 200 && req_valid != 2'b00; k++) begin
      @(negedge clk_in);
      acc = req_valid & req_ready;
      @(posedge clk_in); #1;
      req_valid = req_valid & ~acc;
    end
    wait_done(2);
    chk("t2_nacc", 64'(a_cyc.size()), 64'd2);
    if (a_cyc.size() == 2 && d_cyc.size() >= 1) begin
      chk("t2_first_ch",  64'(a_ch[0]), 64'd0);
      chk("t2_second_ch", 64'(a_ch[1]), 64'd1);
      chk("t2_regrant",   64'(a_cyc[1] - d_cyc[0]), 64'd1);
      chk("t2_done0",     64'(d_val[0]), 64'd1);
      check_wr("t2_ch0", 0, a_cyc[0], 1, 8'h0C, 32'h00000009);
      cnt = 0;
      for (int i = 0; i < w_cyc.size(); i++)
        if (w_cyc[i] > a_cyc[1] && w_addr[i][4]) cnt++;
      chk("t2_ch1_bit4", 64'(cnt), 64'd5);
      check_wr("t2_ch1_dw1", 2, a_cyc[1], 4, 8'h14, 32'hAABBCCDD);
    end

    // ch1 last_only
    clr();
    do_req(1, 1'b1, 16'd0, 64'h0, 16'h0005, 12'h0, t0);
    wait_done(1);
    chk("t3_nwr", 64'(w_cyc.size()), 64'd1);
    check_wr("t3_dw3", 0, t0, 1, 8'h1C, 32'h00000005);
    if (d_cyc.size() > 0) begin
      chk("t3_done_cyc", 64'(d_cyc[0] - t0), 64'd4);
      chk("t3_done_val", 64'(d_val[0]), 64'd2);
    end

    // Size 0xFFFF clamps and flags
    clr();
    do_req(0, 1'b0, 16'hFFFF, 64'h0, 16'h0, 12'h0, t0);
    wait_done(1);
    chk("t4_cfgerr_n", 64'(e_cyc.size()), 64'd1);
    if (e_cyc.size() > 0) chk("t4_cfgerr_cyc", 64'(e_cyc[0] - t0), 64'd1);
    check_wr("t4_dw0", 3, t0, 10, 8'h00, 32'h0000FFFE);
    cnt = 0;
    for (int i = 0; i < w_data.size(); i++) if (w_data[i] == 32'h0000FFFF) cnt++;
    chk("t4_one_srst", 64'(cnt), 64'd1);

    // Reset in the middle of a sequence
    clr();
    do_req(0, 1'b0, 16'd4, 64'h0, 16'h1, 12'h0, t0);
    while (cyc < t0 + 8) @(negedge clk_in);
    #1;
    req_valid = 2'b01;
    rstn = 1'b0;
    #1;
    chk("t5_wrena", 64'(dma_prg_wrena), 64'd0);
    chk("t5_addr",  64'(dma_prg_addr), 64'd0);
    chk("t5_data",  64'(dma_prg_wrdata), 64'd0);
    chk("t5_busy",  64'(busy), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd0);
    chk("t5_done",  64'(done), 64'd0);
    clr();
    repeat (3) @(posedge clk_in);
    req_valid = 2'b00;
    @(negedge clk_in); #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk_in);
    chk("t5_no_done", 64'(d_cyc.size()), 64'd0);
    #1;
    clr();
    do_req(0, 1'b0, 16'd4, 64'h0, 16'h1, 12'h0, t0);
    wait_done(1);
    check_wr("t5_restart", 0, t0, 1, 8'h00, 32'h0000FFFF);

    // Continuous ch0 requests, ch1 idle
    clr();
    set_req(0, 1'b0, 16'd1, 64'h0, 16'h2, 12'h0);
    req_valid = 2'b01;
    for (int k = 0; k < 200 && a_cyc.size() < 3; k++) @(posedge clk_in);
    #1;
    req_valid = 2'b00;
    wait_done(3);
    chk("t6_nacc", 64'(a_cyc.size()), 64'd3);
    if (a_cyc.size() >= 3) begin
      cnt = 0;
      for (int i = 0; i < 3; i++) if (a_ch[i] != 0) cnt++;
      chk("t6_all_ch0", 64'(cnt), 64'd0);
      chk("t6_gap01", 64'(a_cyc[1] - a_cyc[0]), 64'd17);
      chk("t6_gap12", 64'(a_cyc[2] - a_cyc[1]), 64'd17);
    end

    chk("never_both_ready", 64'(both_bad), 64'd0);
    chk("idle_bus_zero",    64'(idle_bad), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/sonic_dma_prg_seq.md
SONIC_DMA_PRG_SEQ -- requirements
Module: sonic_dma_prg_seq

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2, the number of idle cycles inserted after every register write (range 0..15).
REQ-002 The block SHALL have parameter RESET_FIRST, default 1; when 1, every full sequence begins with a soft-reset write.
REQ-003 clk_in  input  1  clock; all logic is rising-edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester request; bit0 = write-DMA channel, bit1 = read-DMA channel.
REQ-006 req_ready  output  2  per-requester acceptance; a request is taken when valid & ready in the same cycle.
REQ-007 req_last_only  input  2  per-requester flag; 1 = write DW3 (rc_last) only.
REQ-008 req_size / req_rc_last  input  2x16 each  descriptor count and RC last index.
REQ-009 req_base  input  2x64  descriptor table base address in RC memory.
REQ-010 req_ctrl  input  2x12  {rundma, msi_tc[2:0], msi_num[4:0], eplast_ena, msi, 1'b0}.
REQ-011 dma_prg_wrena / dma_prg_wrdata / dma_prg_addr  output  1/32/8  register-write port to the DMA programming register block.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 done  output  2  one-cycle pulse per requester on sequence completion.
REQ-014 cfg_err  output  1  one-cycle pulse when an accepted req_size equals 16'hFFFF.

Function
REQ-015 Arbitration SHALL be round-robin between the two requesters; after reset, requester 0 has priority; the pointer advances past the granted requester on every acceptance.
REQ-016 req_ready SHALL be high only in IDLE and only for the single granted requester with valid high; at most one bit of req_ready is high per cycle.
REQ-017 On acceptance, the requester's size, base, rc_last, ctrl, last_only flags and index SHALL be captured; inputs are then don't-care until done.
REQ-018 FSM states: IDLE, SRST, DW1, DW2, DW0, DW3, GAP, DONE.
REQ-019 Full sequence: SRST (if RESET_FIRST) -> DW1 -> DW2 -> DW0 -> DW3 -> DONE. last_only sequence: DW3 -> DONE.
REQ-020 Each write state SHALL drive dma_prg_wrena high for exactly one cycle, then enter GAP for GAP_CYCLES cycles (skipped if 0) before the next state.
REQ-021 dma_prg_addr SHALL be {3'b000, ch, dw[1:0], 2'b00}, where ch = captured requester index and dw = 0..3.
REQ-022 Write data: SRST = 32'h0000FFFF to DW0; DW1 = base[63:32]; DW2 = base[31:0]; DW0 = {ctrl[11], ctrl[10:8], 3'b000, ctrl[7:3], 1'b0, ctrl[2:1], ch, size}; DW3 = {16'h0, rc_last}.
REQ-023 A captured size of 16'hFFFF SHALL be replaced by 16'hFFFE in the DW0 write and SHALL pulse cfg_err in the acceptance+1 cycle; this prevents an unintended soft reset.
REQ-024 DONE SHALL last one cycle, pulse done[ch], and return to IDLE; a new request can be accepted in the following cycle.
REQ-025 Latency with RESET_FIRST=1 and GAP_CYCLES=2, acceptance at cycle 0: writes at cycles 1, 4, 7, 10, 13; done at 16. With GAP_CYCLES=0: writes at cycles 1..5; done at 6.
REQ-026 When dma_prg_wrena is low, dma_prg_wrdata and dma_prg_addr SHALL be held at 0.

Reset
REQ-027 When rstn is asserted, the block SHALL asynchronously force: FSM to IDLE, gap counter to 0, RR pointer to requester 0, captured registers to 0, and all outputs to 0 (req_ready, wrena, wrdata, addr, busy, done, cfg_err).
REQ-028 If reset is asserted mid-sequence, the sequence SHALL be abandoned with no done pulse; after release, the block resumes from IDLE.

Structure
REQ-029 FSM state enum, DW index constants (2'b00..2'b11) and the soft-reset pattern 16'hFFFF SHALL reside in sonic_constants package.
REQ-030 The round-robin arbiter SHALL be a sub-module sonic_rr_arb2 (2 requesters, grant and pointer update on accept); the remainder is flat.

Verification
REQ-031 Single full request on ch0 (size=8, base=64'h1_2345_6780, rc_last=3, GAP_CYCLES=2) -> writes at cycles 1/4/7/10/13: addr 0x00 data 0xFFFF, addr 0x04 data 0x1, addr 0x08 data 0x23456780, addr 0x00 DW0, addr 0x0C data 0x3; done[0] at cycle 16.
REQ-032 Both channels valid simultaneously after reset -> ch0 granted first; ch1 granted in the cycle after done[0]; all ch1 addresses have bit4 = 1.
REQ-033 ch1 last_only with rc_last=16'h0005 -> exactly one write, addr 0x1C data 0x00000005; done[1] at cycle 1+GAP_CYCLES+1.
REQ-034 size=16'hFFFF -> cfg_err pulses once; DW0 write carries low half 16'hFFFE; there is no second 0xFFFF write.
REQ-035 rstn asserted low at cycle 8 of a full sequence -> all outputs are 0 immediately, no done pulse; a new request after release starts again with SRST.
REQ-036 Continuous ch0 requests with ch1 idle -> ch0 is re-granted every sequence; req_ready is never high for both channels.
